mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one pipelined integer multiplier (instantiated beside this block at top level) among NREQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
- A tag pipeline tracks the owner of each in-flight product and routes the product back to that requester.
- A drain FSM stops issue and reports when the multiplier pipeline is empty, so the owning controller can safely reconfigure or idle the datapath.

Parameters:
- W, 64: operand width; must equal the multiplier's DATA_SIZE_ARB.
- NREQ, 4: number of requesters; 2..8.
- MULT_LAT, 3: multiplier latency in edges, from operand capture to C update.
- CNT_W, 32: width of the issue counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant; handshake on requester i = req_valid[i] & req_ready[i].
- mult_a  out  W  registered operand A to multiplier.
- mult_b  out  W  registered operand B to multiplier.
- mult_c  in  2W  multiplier product C.
- resp_valid  out  NREQ  one-hot: product on resp_data belongs to requester i.
- resp_data  out  2W  product; equals mult_c (passthrough).
- drain_req  in  1  request to stop issuing and empty the pipeline.
- idle  out  1  high in IDLE state only.
- inflight  out  clog2(MULT_LAT+2)  number of products currently in flight.
- issue_cnt  out  CNT_W  total accepted requests; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, asynchronous):
  - mult_a, mult_b, tag pipeline, inflight and issue_cnt are cleared to 0.
  - Round-robin pointer is set so requester 0 has highest priority.
  - FSM enters RUN.
  - Outputs during reset: req_ready=0, resp_valid=0, idle=0.
- Arbitration (RUN state only):
  - Search starts at (last_granted+1) mod NREQ and wraps.
  - The first requester with req_valid high gets req_ready.
  - req_ready is combinational from req_valid and state; at most one bit is set.
  - Requesters must not make req_valid depend on req_ready.
  - Pointer updates to the granted index only on an edge where a handshake occurs.
- Issue:
  - On the handshake edge k, mult_a/mult_b load the granted operands.
  - A tag {valid=1, id} enters stage 0 of a (MULT_LAT+1)-stage shift register.
  - With no handshake, mult_a/mult_b hold their value and a tag with valid=0 enters.
- Response:
  - resp_valid[id] is high in the cycle after edge k+MULT_LAT, driven from the last tag stage; resp_data = mult_c in that cycle.
  - Default MULT_LAT=3: handshake at edge k, product sampled at edge k+4.
  - There is no response backpressure; requesters must accept.
- inflight:
  - Counts valid tags in the pipeline.
  - Increments on issue and decrements when a tag retires.
  - Issue and retire on the same edge leave it unchanged.
- issue_cnt: increments by 1 per handshake; wraps to 0 after 2^CNT_W-1.
- FSM:
  - RUN -> DRAIN when drain_req=1. req_ready is forced to 0 in the same cycle drain_req is high (combinational gating).
  - DRAIN -> IDLE on the edge where inflight=0 and no tag is retiring. Tags already issued still produce responses in DRAIN.
  - IDLE -> RUN when drain_req=0. While drain_req stays high the FSM holds IDLE with idle=1.
  - DRAIN with drain_req dropped: the FSM still completes to IDLE, then returns to RUN next edge if drain_req is still 0.
- Back-to-back issue:
  - One issue per cycle with no bubbles.
  - Up to MULT_LAT+1 products may be in flight.
  - Responses return in issue order.
- Reset mid-operation:
  - All in-flight tags are discarded; no resp_valid fires for them.
  - The multiplier is reset by the same top-level reset net, so no stale product is attributed.

Test Plan:
1. Single request: requester 2 with A=0xFFFF_FFFF_FFFF_FFFF, B=2, handshake at edge k -> resp_valid=4'b0100 in the cycle before edge k+4; resp_data=0x1_FFFF_FFFF_FFFF_FFFE; issue_cnt=1.
2. All 4 requesters valid continuously, A=i+1, B=10 -> grants in order 0,1,2,3,0,...; one issue per cycle; responses 10,20,30,40 in the same order, 4 edges after each grant; inflight saturates at 4.
3. Round-robin fairness: requesters 1 and 3 valid continuously, pointer starting at 0 -> grants alternate 1,3,1,3; neither requester waits more than 1 cycle.
4. Drain: 3 products in flight, drain_req asserted -> req_ready=0 immediately; all 3 responses still delivered; idle=1 on the edge after the last retire. drain_req then released -> RUN next edge and grants resume.
5. Reset asserted asynchronously with 2 products in flight -> req_ready, resp_valid and inflight drop to 0 without a clock edge. After release, no resp_valid occurs for the lost products and requester 0 is granted first.
6. issue_cnt wrap (CNT_W=4): 17 handshakes -> issue_cnt reads 1.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//
// Purpose:
//   Shares a single pipelined integer multiplier (instantiated next to this
//   block) among NREQ requesters. A round-robin arbiter accepts at most one
//   operand pair per cycle and registers it onto the multiplier inputs. A tag
//   shift register, MULT_LAT+1 stages long, follows each operand pair through
//   the multiplier. When the pair reaches the last stage, the matching product
//   is on mult_c, and the tag steers it back to the requester that issued it.
//   A small RUN/DRAIN/IDLE FSM stops new issue on request. It reports idle once
//   every issued product has come back, so the owning controller can
//   reconfigure or idle the datapath safely.
//
// Parameters:
//   W         operand width (must match the multiplier operand width)
//   NREQ      number of requesters, 2..8
//   MULT_LAT  multiplier latency in clock edges
//   CNT_W     width of the accepted-request counter
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   req_valid   per-requester request valid
//   req_a/req_b packed operands, requester i at [i*W +: W]
//   req_ready   one-hot grant; handshake = req_valid[i] & req_ready[i]
//   mult_a/b    registered operands driven into the multiplier
//   mult_c      multiplier product
//   resp_valid  one-hot owner of the product currently on resp_data
//   resp_data   product (direct copy of mult_c)
//   drain_req   stop issuing and empty the multiplier pipeline
//   idle        high while the FSM sits in IDLE
//   inflight    number of products currently inside the multiplier
//   issue_cnt   number of accepted requests, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int W        = 64,
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 3,
    parameter int CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*W-1:0]             req_a,
    input  logic [NREQ*W-1:0]             req_b,
    output logic [NREQ-1:0]               req_ready,
    output logic [W-1:0]                  mult_a,
    output logic [W-1:0]                  mult_b,
    input  logic [2*W-1:0]                mult_c,
    output logic [NREQ-1:0]               resp_valid,
    output logic [2*W-1:0]                resp_data,
    input  logic                          drain_req,
    output logic                          idle,
    output logic [$clog2(MULT_LAT+2)-1:0] inflight,
    output logic [CNT_W-1:0]              issue_cnt
);

    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int INF_W = $clog2(MULT_LAT + 2);
    localparam int LAST  = MULT_LAT;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    genvar gi;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_reg;
    logic               idle_reg;
    logic [ID_W-1:0]    last_grant_reg;
    logic [W-1:0]       mult_a_reg;
    logic [W-1:0]       mult_b_reg;
    logic [MULT_LAT:0]  tag_valid_reg;
    logic [ID_W-1:0]    tag_id_reg [MULT_LAT+1];
    logic [INF_W-1:0]   inflight_reg;
    logic [CNT_W-1:0]   issue_cnt_reg;

    // ---------------------------------------------------------------------
    // Combinational arbitration
    // ---------------------------------------------------------------------
    logic               run_ok;
    logic [NREQ-1:0]    elig_req;
    logic [NREQ-1:0]    higher_mask;
    logic [NREQ-1:0]    masked_req;
    logic [NREQ-1:0]    pick_src;
    logic [NREQ-1:0]    grant_onehot;
    logic [ID_W-1:0]    grant_id;
    logic               handshake;
    logic               retire;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic [INF_W-1:0]   inflight_next;

    // Grants are only offered in RUN and not in a cycle that drain_req is
    // high. Gating with reset keeps req_ready low during reset. Without it,
    // the FSM's reset state (RUN) would already expose grants.
    assign run_ok   = reset && (state_reg == ST_RUN) && !drain_req;
    assign elig_req = run_ok ? req_valid : '0;

    // Requesters with a higher index than the last winner are searched first.
    // If none of them is asking, the search wraps to the lowest index.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign higher_mask[gi] = (ID_W'(gi) > last_grant_reg);
        end
    endgenerate

    assign masked_req = elig_req & higher_mask;
    assign pick_src   = (|masked_req) ? masked_req : elig_req;
    // Isolate the lowest set bit; the result is a one-hot (or zero) grant.
    assign grant_onehot = pick_src & (~pick_src + NREQ'(1));
    assign handshake    = |grant_onehot;

    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) begin
                grant_id = ID_W'(i);
                sel_a    = req_a[i*W +: W];
                sel_b    = req_b[i*W +: W];
            end
        end
    end

    // A tag leaves the pipeline on the edge that follows its product
    // appearing on mult_c.
    assign retire        = tag_valid_reg[LAST];
    assign inflight_next = inflight_reg + INF_W'(handshake) - INF_W'(retire);

    // ---------------------------------------------------------------------
    // Issue datapath, tag pipeline and counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_a_reg     <= '0;
            mult_b_reg     <= '0;
            last_grant_reg <= ID_W'(NREQ - 1);   // requester 0 searched first
            tag_valid_reg  <= '0;
            for (int i = 0; i <= MULT_LAT; i++) begin
                tag_id_reg[i] <= '0;
            end
            inflight_reg   <= '0;
            issue_cnt_reg  <= '0;
        end else begin
            if (handshake) begin
                mult_a_reg     <= sel_a;
                mult_b_reg     <= sel_b;
                last_grant_reg <= grant_id;
                issue_cnt_reg  <= issue_cnt_reg + CNT_W'(1);
            end
            // A bubble (valid=0) enters on cycles without a handshake, so the
            // tag position always matches the product position in the
            // multiplier.
            tag_valid_reg <= {tag_valid_reg[MULT_LAT-1:0], handshake};
            tag_id_reg[0] <= grant_id;
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag_id_reg[i] <= tag_id_reg[i-1];
            end
            inflight_reg <= inflight_next;
        end
    end

    // ---------------------------------------------------------------------
    // Drain FSM
    // ---------------------------------------------------------------------
    // DRAIN keeps going to IDLE even if drain_req drops early. The controller
    // therefore always sees one idle cycle before issue resumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            idle_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (drain_req) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_reg == '0) && !retire) begin
                        state_reg <= ST_IDLE;
                        idle_reg  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!drain_req) begin
                        state_reg <= ST_RUN;
                        idle_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    idle_reg  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Response routing
    // ---------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_resp
            assign resp_valid[gi] = tag_valid_reg[LAST] &&
                                    (tag_id_reg[LAST] == ID_W'(gi));
        end
    endgenerate

    assign resp_data = mult_c;
    assign req_ready = grant_onehot;
    assign mult_a    = mult_a_reg;
    assign mult_b    = mult_b_reg;
    assign idle      = idle_reg;
    assign inflight  = inflight_reg;
    assign issue_cnt = issue_cnt_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Directed bench for mult_share_arbiter. A behavioural multiplier with
// MULT_LAT register stages sits beside the DUT, and the same top-level reset
// clears it. A second instance with a 4-bit issue counter gets the same
// stimulus and is used for the counter wrap check.
// ---------------------------------------------------------------------------
module tb_mult_share_arbiter;

    localparam int W        = 64;
    localparam int NREQ     = 4;
    localparam int MULT_LAT = 3;
    localparam int INF_W    = $clog2(MULT_LAT + 2);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic                drain_req = 1'b0;

    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        mult_a;
    logic [W-1:0]        mult_b;
    logic [2*W-1:0]      mult_c;
    logic [NREQ-1:0]     resp_valid;
    logic [2*W-1:0]      resp_data;
    logic                idle;
    logic [INF_W-1:0]    inflight;
    logic [31:0]         issue_cnt;

    logic [NREQ-1:0]     req_ready_w;
    logic [W-1:0]        mult_a_w;
    logic [W-1:0]        mult_b_w;
    logic [NREQ-1:0]     resp_valid_w;
    logic [2*W-1:0]      resp_data_w;
    logic                idle_w;
    logic [INF_W-1:0]    inflight_w;
    logic [3:0]          issue_cnt_w;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .MULT_LAT(MULT_LAT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
        .resp_valid(resp_valid), .resp_data(resp_data), .drain_req(drain_req),
        .idle(idle), .inflight(inflight), .issue_cnt(issue_cnt)
    );

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .MULT_LAT(MULT_LAT), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready_w), .mult_a(mult_a_w), .mult_b(mult_b_w), .mult_c(mult_c),
        .resp_valid(resp_valid_w), .resp_data(resp_data_w), .drain_req(drain_req),
        .idle(idle_w), .inflight(inflight_w), .issue_cnt(issue_cnt_w)
    );

    always #5 clk = ~clk;

    // Multiplier model: the product of the registered operands becomes
    // visible on mult_c MULT_LAT edges after they are captured.
    logic [2*W-1:0] p1, p2, p3;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            p1 <= {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign mult_c = p3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [3:0] onehot(input int i);
        onehot = 4'b0001 << i;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
            $display("ok   %s = 0x%0h", tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int exp2 [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int inf2 [12] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1};
    int exp3 [4] = '{3, 1, 3, 1};
    int dat3 [4] = '{54, 35, 54, 35};

    initial begin
        // ---------------- reset state ----------------
        req_valid = 4'hF;
        settle();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_idle", idle, 0);
        check("rst_inflight", inflight, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_mult_a", mult_a, 0);
        req_valid = '0;
        tick();
        reset = 1'b1;

        // ---------------- 1: single request ----------------
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        req_valid = 4'b0100;
        settle();
        check("t1_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        settle();
        check("t1_mult_a", mult_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_mult_b", mult_b, 64'd2);
        check("t1_issue_cnt", issue_cnt, 1);
        check("t1_inflight", inflight, 1);
        tick();
        tick();
        check("t1_no_early_resp", resp_valid, 0);
        tick();
        check("t1_resp_valid", resp_valid, 4'b0100);
        check("t1_resp_data", resp_data, 128'h1_FFFF_FFFF_FFFF_FFFE);
        tick();
        check("t1_resp_done", resp_valid, 0);
        check("t1_inflight_end", inflight, 0);

        // ---------------- 2: all requesters, back-to-back ----------------
        for (int i = 0; i < NREQ; i++) set_op(i, 64'(i + 1), 64'd10);
        for (int n = 0; n < 12; n++) begin
            req_valid = (n < 8) ? 4'hF : 4'h0;
            settle();
            if (n < 8) check($sformatf("t2_grant%0d", n), req_ready, onehot(exp2[n]));
            if (n >= 4) begin
                check($sformatf("t2_resp_valid%0d", n - 4), resp_valid, onehot(exp2[n-4]));
                check($sformatf("t2_resp_data%0d", n - 4), resp_data, 128'((exp2[n-4] + 1) * 10));
            end
            check($sformatf("t2_inflight%0d", n), inflight, inf2[n]);
            tick();
        end
        check("t2_inflight_end", inflight, 0);
        check("t2_issue_cnt", issue_cnt, 9);

        // ---------------- 3: fairness between 1 and 3 ----------------
        set_op(1, 64'd5, 64'd7);
        set_op(3, 64'd6, 64'd9);
        for (int n = 0; n < 8; n++) begin
            req_valid = (n < 4) ? 4'b1010 : 4'b0000;
            settle();
            if (n < 4) check($sformatf("t3_grant%0d", n), req_ready, onehot(exp3[n]));
            if (n >= 4) begin
                check($sformatf("t3_resp_valid%0d", n - 4), resp_valid, onehot(exp3[n-4]));
                check($sformatf("t3_resp_data%0d", n - 4), resp_data, 128'(dat3[n-4]));
            end
            tick();
        end

        // ---------------- 4: drain ----------------
        set_op(0, 64'd3, 64'd4);
        req_valid = 4'b0001;
        settle();
        check("t4_grant", req_ready, 4'b0001);
        tick();
        tick();
        tick();
        drain_req = 1'b1;
        settle();
        check("t4_ready_gated", req_ready, 0);
        check("t4_inflight3", inflight, 3);
        tick();
        check("t4_drain_ready", req_ready, 0);
        check("t4_drain_idle", idle, 0);
        check("t4_resp0_valid", resp_valid, 4'b0001);
        check("t4_resp0_data", resp_data, 128'd12);
        tick();
        check("t4_resp1_valid", resp_valid, 4'b0001);
        tick();
        check("t4_resp2_valid", resp_valid, 4'b0001);
        check("t4_resp2_data", resp_data, 128'd12);
        check("t4_inflight1", inflight, 1);
        tick();
        check("t4_resp_done", resp_valid, 0);
        check("t4_inflight0", inflight, 0);
        check("t4_not_idle_yet", idle, 0);
        tick();
        check("t4_idle", idle, 1);
        tick();
        check("t4_idle_hold", idle, 1);
        check("t4_no_issue", issue_cnt, 16);
        drain_req = 1'b0;
        settle();
        check("t4_idle_no_grant", req_ready, 0);
        tick();
        check("t4_run_idle", idle, 0);
        check("t4_resume_grant", req_ready, 4'b0001);

        // ---------------- 5: async reset mid-flight ----------------
        set_op(1, 64'd5, 64'd7);
        req_valid = 4'b0010;
        tick();
        tick();
        check("t5_inflight2", inflight, 2);
        req_valid = 4'hF;
        reset = 1'b0;
        settle();
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_resp", resp_valid, 0);
        check("t5_rst_inflight", inflight, 0);
        check("t5_rst_issue_cnt", issue_cnt, 0);
        tick();
        tick();
        reset = 1'b1;
        settle();
        check("t5_first_grant", req_ready, 4'b0001);
        req_valid = '0;
        for (int n = 0; n < 6; n++) begin
            tick();
            check($sformatf("t5_no_stale_resp%0d", n), resp_valid, 0);
        end

        // ---------------- 6: issue counter wrap ----------------
        req_valid = 4'b0001;
        repeat (16) tick();
        check("t6_cnt4_at16", issue_cnt_w, 0);
        check("t6_cnt32_at16", issue_cnt, 16);
        tick();
        req_valid = '0;
        check("t6_cnt4_at17", issue_cnt_w, 1);
        check("t6_cnt32_at17", issue_cnt, 17);
        repeat (6) tick();
        check("t6_inflight_end", inflight, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
